// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with same-cycle write bypass and a
// per-register pending-write scoreboard sitting between decode and writeback.
module reg_file_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NREAD    = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS),
    localparam int unsigned CW      = AW + 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_rd,
    output logic                  issue_waw,
    output logic [CW-1:0]         pending_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_ok, issue_ok, cnt_inc, cnt_dec;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Scoreboard next state: a same-cycle issue overrides the write's clear.
    always_comb begin
        wr_ok    = wr_en && !is_zero(wr_addr);
        issue_ok = issue_en && !is_zero(issue_rd);
        busy_d   = busy_q;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[issue_rd] = 1'b1;
        end
        cnt_inc = issue_ok && !busy_q[issue_rd];
        cnt_dec = wr_ok && busy_q[wr_addr] && !(issue_ok && (issue_rd == wr_addr));
        cnt_d   = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
            end
        end
    end

    // Independent combinational read ports; register 0 check has final say.
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   addr_c;
        logic [XLEN-1:0] data_c;
        logic            busy_c;

        assign addr_c = rd_addr[k*AW +: AW];

        always_comb begin
            data_c = regs_q[addr_c];
            busy_c = busy_q[addr_c];
            if (BYPASS && wr_en && (wr_addr == addr_c)) begin
                data_c = wr_data;
                busy_c = 1'b0;
            end
            if (is_zero(addr_c)) begin
                data_c = '0;
                busy_c = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data_c;
        assign rd_busy[k]              = busy_c;
    end

    assign issue_waw   = issue_en && busy_q[issue_rd] && !is_zero(issue_rd);
    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic against an array-based architectural model (bypass and no-bypass).
module tb_reg_file_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NR   = 32;
    localparam int unsigned AW   = 5;

    logic            clock = 1'b0;
    logic            resetn;
    logic [2*AW-1:0] rd_addr;
    logic [63:0]     rd_data, rd_data_nb;
    logic [1:0]      rd_busy, rd_busy_nb;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [31:0]     wr_data;
    logic            issue_en;
    logic [AW-1:0]   issue_rd;
    logic            issue_waw, issue_waw_nb;
    logic [AW:0]     pending_cnt, pending_cnt_nb;

    int checks = 0;
    int errors = 0;

    // Architectural model: register values and outstanding destinations.
    logic [31:0] m_regs [NR];
    bit          m_busy [NR];

    always #5 clock = ~clock;

    reg_file_sb dut (
        .clock(clock), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_waw(issue_waw),
        .pending_cnt(pending_cnt)
    );

    reg_file_sb #(.BYPASS(1'b0)) dut_nb (
        .clock(clock), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_waw(issue_waw_nb),
        .pending_cnt(pending_cnt_nb)
    );

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < int'(NR); i++) n += int'(m_busy[i]);
        return n;
    endfunction

    // Advance one edge and apply the same edge to the model.
    task automatic tick();
        @(posedge clock);
        if (!resetn) begin
            for (int i = 0; i < int'(NR); i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        issue_en = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; idle();
        wr_addr = '0; wr_data = '0; issue_rd = '0; rd_addr = '0;
        tick(); tick();
        resetn  = 1'b1;
        rd_addr = {5'd31, 5'd5};
        #1;
        checks++;
        if (rd_data !== 64'd0 || rd_busy !== 2'b00 || pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: data=%h busy=%b cnt=%0d, want 0/00/0", rd_data, rd_busy, pending_cnt);
        end
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_addr = {5'd5, 5'd5};
        #1;
        checks++;
        if (rd_data !== {2{32'hDEADBEEF}} || rd_data_nb !== {2{32'hDEADBEEF}}) begin
            errors++;
            $display("FAIL write_then_read: got %h / %h, want deadbeef on both ports", rd_data, rd_data_nb);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        rd_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h12345678 || rd_data[63:32] !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_on: got %h, want 12345678 on both ports", rd_data);
        end
        checks++;
        if (rd_data_nb[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL bypass_off: got %h, want 00000000", rd_data_nb[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data_nb[31:0] !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_off_next: got %h, want 12345678", rd_data_nb[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_rd = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rd_data !== 64'd0 || rd_busy !== 2'b00 || issue_waw !== 1'b0) begin
            errors++;
            $display("FAIL zero_same_cycle: data=%h busy=%b waw=%b, want 0/00/0", rd_data, rd_busy, issue_waw);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data !== 64'd0 || rd_busy !== 2'b00 || pending_cnt !== 6'd0) begin
            errors++;
            $display("FAIL zero_after: data=%h busy=%b cnt=%0d, want 0/00/0", rd_data, rd_busy, pending_cnt);
        end
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_rd = 5'd3;
        rd_addr  = {5'd3, 5'd3};
        #1;
        checks++;
        if (rd_busy !== 2'b00 || issue_waw !== 1'b0) begin
            errors++;
            $display("FAIL issue_same_cycle: busy=%b waw=%b, want 00/0", rd_busy, issue_waw);
        end
        tick();
        checks++;
        if (rd_busy !== 2'b11 || pending_cnt !== 6'd1 || issue_waw !== 1'b1) begin
            errors++;
            $display("FAIL issue_visible: busy=%b cnt=%0d waw=%b, want 11/1/1", rd_busy, pending_cnt, issue_waw);
        end
        issue_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h000000A5;
        #1;
        checks++;
        if (rd_busy !== 2'b00 || rd_busy_nb !== 2'b11 || rd_data[31:0] !== 32'hA5) begin
            errors++;
            $display("FAIL commit_bypass: busy=%b nb_busy=%b data=%h, want 00/11/a5", rd_busy, rd_busy_nb, rd_data[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy !== 2'b00 || pending_cnt !== 6'd0 || rd_data_nb[31:0] !== 32'hA5) begin
            errors++;
            $display("FAIL commit_after: busy=%b cnt=%0d data=%h, want 00/0/a5", rd_busy, pending_cnt, rd_data_nb[31:0]);
        end
    endtask

    task automatic test_collisions();
        issue_en = 1'b1; issue_rd = 5'd4;
        tick();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11;
        #1;
        checks++;
        if (issue_waw !== 1'b1) begin
            errors++;
            $display("FAIL waw_with_write: got %b, want 1", issue_waw);
        end
        tick();
        idle();
        rd_addr = {5'd4, 5'd4};
        #1;
        checks++;
        if (rd_busy !== 2'b11 || rd_data_nb[31:0] !== 32'h11 || pending_cnt !== 6'd1) begin
            errors++;
            $display("FAIL same_reg_collision: busy=%b data=%h cnt=%0d, want 11/11/1", rd_busy, rd_data_nb[31:0], pending_cnt);
        end
        issue_en = 1'b1; issue_rd = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h22;
        tick();
        idle();
        rd_addr = {5'd9, 5'd4};
        #1;
        checks++;
        if (rd_busy !== 2'b10 || pending_cnt !== 6'd1 || pending_cnt_nb !== 6'd1) begin
            errors++;
            $display("FAIL diff_reg_collision: busy=%b cnt=%0d/%0d, want 10/1/1", rd_busy, pending_cnt, pending_cnt_nb);
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [31:0]   ed, ed_nb;
        logic          eb, eb_nb, ew;
        for (int c = 0; c < 600; c++) begin
            resetn   = ($urandom_range(0, 79) != 0);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_addr  = AW'($urandom_range(0, 31));
            wr_data  = $urandom;
            issue_en = $urandom_range(0, 2) != 0;
            issue_rd = AW'($urandom_range(0, 31));
            for (int k = 0; k < 2; k++) begin
                a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 31));
                rd_addr[k*AW +: AW] = a;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                a = rd_addr[k*AW +: AW];
                ed_nb = (a == 0) ? 32'd0 : m_regs[a];
                eb_nb = (a != 0) && m_busy[a];
                ed = ed_nb; eb = eb_nb;
                if (a != 0 && wr_en && wr_addr == a) begin
                    ed = wr_data; eb = 1'b0;
                end
                checks++;
                if (rd_data[k*32 +: 32] !== ed || rd_busy[k] !== eb) begin
                    errors++;
                    $display("FAIL rand_read_bp c=%0d port=%0d: data=%h busy=%b, want %h/%b", c, k, rd_data[k*32 +: 32], rd_busy[k], ed, eb);
                end
                checks++;
                if (rd_data_nb[k*32 +: 32] !== ed_nb || rd_busy_nb[k] !== eb_nb) begin
                    errors++;
                    $display("FAIL rand_read_nb c=%0d port=%0d: data=%h busy=%b, want %h/%b", c, k, rd_data_nb[k*32 +: 32], rd_busy_nb[k], ed_nb, eb_nb);
                end
            end
            ew = issue_en && issue_rd != 0 && m_busy[issue_rd];
            checks++;
            if (issue_waw !== ew || int'(pending_cnt) != model_count() || pending_cnt_nb !== pending_cnt) begin
                errors++;
                $display("FAIL rand_sb c=%0d: waw=%b cnt=%0d/%0d, want %b/%0d", c, issue_waw, pending_cnt, pending_cnt_nb, ew, model_count());
            end
            tick();
        end
        resetn = 1'b1;
        idle();
    endtask

    task automatic test_reset_mid();
        resetn = 1'b0; tick(); resetn = 1'b1;
        for (int r = 10; r < 16; r++) begin
            wr_en = 1'b1; wr_addr = AW'(r); wr_data = 32'h1111 * r;
            tick();
        end
        wr_en = 1'b0;
        for (int r = 10; r < 16; r++) begin
            issue_en = 1'b1; issue_rd = AW'(r);
            tick();
        end
        idle();
        rd_addr = {5'd15, 5'd10};
        #1;
        checks++;
        if (pending_cnt !== 6'd6 || rd_busy !== 2'b11 || rd_data[31:0] !== 32'h0000AAAA) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d busy=%b data=%h, want 6/11/0000aaaa", pending_cnt, rd_busy, rd_data[31:0]);
        end
        resetn = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFEF00D;
        issue_en = 1'b1; issue_rd = 5'd20;
        tick();
        resetn = 1'b1;
        idle();
        for (int r = 10; r < 21; r++) begin
            rd_addr = {AW'(r), AW'(r)};
            #1;
            checks++;
            if (rd_data !== 64'd0 || rd_busy !== 2'b00 || pending_cnt !== 6'd0) begin
                errors++;
                $display("FAIL reset_mid x%0d: data=%h busy=%b cnt=%0d, want 0/00/0", r, rd_data, rd_busy, pending_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_collisions();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
